spike_rate_window: RTL and testbench
====================================

SPIKE_RATE_WINDOW -- requirements
Module: spike_rate_window

Interface
REQ-001 SHALL have parameter WIN_LEN, default 16: enabled samples per window; legal range 2..255.
REQ-002 SHALL have parameter RATE_THRESH, default 8: spike count at or above which a window fires; legal range 1..WIN_LEN.
REQ-003 SHALL derive localparam CNT_W = clog2(WIN_LEN+1), the width of every spike count.
REQ-004 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port spike_in, input, 1: registered output-neuron decision (second-layer y).
REQ-007 SHALL have port en, input, 1: sample strobe; spike_in is sampled only on edges where en=1.
REQ-008 SHALL have port clear, input, 1: synchronous restart of the current window.
REQ-009 SHALL have port out_valid, output, 1: a window result is held at the output.
REQ-010 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-011 SHALL have port out_count, output, CNT_W: number of spikes in the head result.
REQ-012 SHALL have port out_fire, output, 1: head result satisfies out_count >= RATE_THRESH.
REQ-013 SHALL have port overflow, output, 1: sticky flag; a completed window was dropped.

Function
REQ-014 SHALL keep a sample counter (0..WIN_LEN-1) and a spike counter (0..WIN_LEN); each enabled edge increments the sample counter and adds spike_in to the spike counter.
REQ-015 SHALL close the window on the enabled edge that takes sample number WIN_LEN; the result is spike counter + spike_in at that edge.
REQ-016 SHALL reset both counters on the closing edge so that the next enabled edge is sample 1 of the next window, with no dead cycle.
REQ-017 SHALL push the closed-window result {count, fire} into a 2-entry FIFO; out_valid SHALL be high in the cycle immediately after the closing edge when the FIFO was empty (one-edge latency).
REQ-018 SHALL drive out_valid = FIFO non-empty, and out_count/out_fire from the FIFO head; they SHALL be stable while out_valid=1 and out_ready=0.
REQ-019 SHALL pop the head on any edge where out_valid=1 and out_ready=1.
REQ-020 SHALL evaluate a push against occupancy after a same-edge pop: when the FIFO is full and a pop and a push coincide, the push is accepted.
REQ-021 SHALL drop the result and set overflow when the FIFO is full at window close and no pop occurs; FIFO contents SHALL be unchanged.
REQ-022 SHALL zero both counters on clear=1, discarding the partial window; FIFO contents and overflow SHALL be kept.
REQ-023 SHALL give clear priority over a same-edge window close: no push occurs and the sample is discarded.
REQ-024 SHALL leave counters unchanged on edges with en=0 and clear=0; pops still proceed.
REQ-025 SHALL never saturate or wrap out_count: a window of all spikes yields exactly WIN_LEN.

Reset
REQ-026 SHALL, while rst=1 and independent of clk, force counters=0, FIFO empty, out_valid=0, out_count=0, out_fire=0 and overflow=0.
REQ-027 SHALL discard any partial window and any buffered results when rst is asserted mid-operation; the first window after release starts at sample 1.

Structure
REQ-028 SHALL place the default WIN_LEN and RATE_THRESH values and the FIFO depth (2) in shared package spike_pkg.
REQ-029 SHALL implement the buffer as the sub-module spike_result_fifo (depth 2, width CNT_W+1, push/pop/full/empty, asynchronous active-high reset).

Verification
REQ-030 SHALL cover the basic window: WIN_LEN=16, en=1 always, spike_in high on 9 of 16 samples -> out_valid one edge after sample 16, out_count=9, out_fire=1.
REQ-031 SHALL cover the threshold boundary: windows with 7 spikes and with 8 spikes -> out_fire=0 and out_fire=1 respectively; 16 spikes -> out_count=16.
REQ-032 SHALL cover backpressure: out_ready=0 over 3 windows -> two results held in order, third dropped, overflow=1; out_ready=1 then drains both results in order.
REQ-033 SHALL cover the full-FIFO coincidence: FIFO full, out_ready=1 on the closing edge -> oldest result popped, new result accepted, overflow stays 0.
REQ-034 SHALL cover clear: clear after sample 10, then 16 samples with 4 spikes -> out_count=4; clear on the closing edge -> no result.
REQ-035 SHALL cover mid-window reset and gated enable: rst pulsed at sample 5 -> all outputs 0; en toggling every other cycle -> window closes after 16 enabled samples (32 cycles).

Source files
------------

// File: rtl/spike_pkg.sv
// ----------------------------------------------------------------------------
// spike_pkg: shared defaults for the spike-rate window and its result buffer.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package spike_pkg;
  localparam int DEF_WIN_LEN     = 16;
  localparam int DEF_RATE_THRESH = 8;
  localparam int FIFO_DEPTH      = 2;
endpackage

`default_nettype wire

// File: rtl/spike_result_fifo.sv
// ----------------------------------------------------------------------------
// spike_result_fifo: small result buffer; a push is accepted when full if a pop
// happens on the same edge. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spike_result_fifo
  import spike_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int DEPTH  = FIFO_DEPTH,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [PTR_W-1:0] c_last_ptr = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W-1:0] c_depth    = OCC_W'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [OCC_W-1:0] r_occ;
  logic             w_wr_en;
  logic             w_rd_en;

  assign o_full  = (r_occ == c_depth);
  assign o_empty = (r_occ == '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_rd_en = i_pop && !o_empty;
  // Occupancy is judged after a same-edge pop, so full+pop still takes a push.
  assign w_wr_en = i_push && (!o_full || w_rd_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= (r_wr_ptr == c_last_ptr) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_rd_en) begin
        r_rd_ptr <= (r_rd_ptr == c_last_ptr) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_wr_en, w_rd_en})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/spike_rate_window.sv
// ----------------------------------------------------------------------------
// spike_rate_window: counts spikes over WIN_LEN enabled samples and queues
// {count, fire} per closed window. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spike_rate_window
  import spike_pkg::*;
#(
  parameter int WIN_LEN     = DEF_WIN_LEN,
  parameter int RATE_THRESH = DEF_RATE_THRESH,
  localparam int CNT_W      = $clog2(WIN_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spike_in,
  input  logic             en,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_fire,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] c_last_samp = CNT_W'(WIN_LEN - 1);
  localparam logic [CNT_W-1:0] c_thresh    = CNT_W'(RATE_THRESH);

  logic [CNT_W-1:0] r_samp_cnt;
  logic [CNT_W-1:0] r_spk_cnt;
  logic             r_overflow;
  logic [CNT_W-1:0] w_win_cnt;
  logic             w_close;
  logic             w_pop;
  logic             w_push;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W:0]   w_head;

  assign w_win_cnt = r_spk_cnt + CNT_W'(spike_in);
  // Clear wins over a coincident close: the closing sample is simply lost.
  assign w_close   = en && !clear && (r_samp_cnt == c_last_samp);
  assign w_pop     = !w_empty && out_ready;
  assign w_push    = w_close && (!w_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp_cnt <= '0;
      r_spk_cnt  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (clear || w_close) begin
        r_samp_cnt <= '0;
        r_spk_cnt  <= '0;
      end else if (en) begin
        r_samp_cnt <= r_samp_cnt + CNT_W'(1);
        r_spk_cnt  <= w_win_cnt;
      end
      if (w_close && w_full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  spike_result_fifo #(
    .WIDTH (CNT_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({w_win_cnt, (w_win_cnt >= c_thresh)}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign out_valid = !w_empty;
  assign out_count = w_empty ? '0 : w_head[CNT_W:1];
  assign out_fire  = !w_empty && w_head[0];
  assign overflow  = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_spike_rate_window.sv
// ----------------------------------------------------------------------------
// tb_spike_rate_window: directed vectors with hand-computed expected results.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_spike_rate_window;

  logic       clk = 1'b0;
  logic       rst;
  logic       spike_in;
  logic       en;
  logic       clear;
  logic       out_ready;
  logic       out_valid;
  logic [4:0] out_count;
  logic       out_fire;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  spike_rate_window #(
    .WIN_LEN     (16),
    .RATE_THRESH (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .spike_in  (spike_in),
    .en        (en),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_fire  (out_fire),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic e, input logic s, input logic c);
    en       = e;
    spike_in = s;
    clear    = c;
    @(posedge clk);
    #1;
  endtask

  // 16 enabled samples, bit i of mask is sample i+1; ready only on the last edge.
  task automatic send_window(input logic [15:0] mask, input logic rdy_last);
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) tick(1'b1, mask[i], 1'b0);
    out_ready = rdy_last;
    tick(1'b1, mask[15], 1'b0);
    out_ready = 1'b0;
    en        = 1'b0;
    spike_in  = 1'b0;
  endtask

  task automatic pop_one();
    out_ready = 1'b1;
    tick(1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; spike_in = 1'b0; en = 1'b0; clear = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_count", out_count, 0);
    check("rst_fire",  out_fire,  0);
    check("rst_ovf",   overflow,  0);
    rst = 1'b0;

    // basic window, 9 spikes
    for (int i = 0; i < 15; i++) tick(1'b1, i[0] | (i == 0) ? 1'b1 : 1'b0, 1'b0);
    check("basic_early_valid", out_valid, 0);
    tick(1'b1, 1'b1, 1'b0);
    en = 1'b0; spike_in = 1'b0;
    check("basic_valid", out_valid, 1);
    check("basic_count", out_count, 9);
    check("basic_fire",  out_fire,  1);
    pop_one();
    check("basic_popped", out_valid, 0);

    // threshold boundary
    send_window(16'h007F, 1'b0);
    check("th7_count", out_count, 7);
    check("th7_fire",  out_fire,  0);
    pop_one();
    send_window(16'h00FF, 1'b0);
    check("th8_count", out_count, 8);
    check("th8_fire",  out_fire,  1);
    pop_one();
    send_window(16'hFFFF, 1'b0);
    check("th16_count", out_count, 16);
    check("th16_fire",  out_fire,  1);
    pop_one();

    // backpressure: 3 windows, third dropped
    send_window(16'h0007, 1'b0);
    check("bp1_count", out_count, 3);
    send_window(16'h001F, 1'b0);
    check("bp2_head", out_count, 3);
    check("bp2_ovf",  overflow,  0);
    send_window(16'h003F, 1'b0);
    check("bp3_ovf",   overflow,  1);
    check("bp3_head",  out_count, 3);
    check("bp3_valid", out_valid, 1);
    pop_one();
    check("bp_drain1_valid", out_valid, 1);
    check("bp_drain1_count", out_count, 5);
    pop_one();
    check("bp_drain2_valid", out_valid, 0);
    check("bp_ovf_sticky",   overflow,  1);

    // reset pulse with overflow set, then full-FIFO coincidence
    rst = 1'b1;
    #2;
    check("rst2_ovf",   overflow,  0);
    check("rst2_valid", out_valid, 0);
    rst = 1'b0;
    send_window(16'h0003, 1'b0);
    send_window(16'h000F, 1'b0);
    check("coin_full_head", out_count, 2);
    send_window(16'h03FF, 1'b1);
    check("coin_head",  out_count, 4);
    check("coin_ovf",   overflow,  0);
    check("coin_valid", out_valid, 1);
    pop_one();
    check("coin_new_count", out_count, 10);
    check("coin_new_fire",  out_fire,  1);
    pop_one();
    check("coin_empty", out_valid, 0);

    // clear mid-window and on the closing edge
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 1'b1);
    check("clr_valid", out_valid, 0);
    send_window(16'h000F, 1'b0);
    check("clr_count", out_count, 4);
    check("clr_fire",  out_fire,  0);
    pop_one();
    for (int i = 0; i < 15; i++) tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    clear = 1'b0; en = 1'b0;
    check("clr_close_valid", out_valid, 0);
    send_window(16'h0001, 1'b0);
    check("clr_after_count", out_count, 1);
    pop_one();

    // mid-window reset with a buffered result
    send_window(16'h00FF, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, 1'b1, 1'b0);
    en = 1'b0;
    rst = 1'b1;
    #2;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_count", out_count, 0);
    check("mid_rst_fire",  out_fire,  0);
    check("mid_rst_ovf",   overflow,  0);
    rst = 1'b0;

    // gated enable: en high on every second cycle, spike_in held high
    for (int c = 1; c <= 32; c++) begin
      tick((c % 2) == 0, 1'b1, 1'b0);
      if (c == 31) check("gate_early_valid", out_valid, 0);
    end
    en = 1'b0; spike_in = 1'b0;
    check("gate_valid", out_valid, 1);
    check("gate_count", out_count, 16);
    check("gate_fire",  out_fire,  1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
